// File: rtl/md_ctrl_if.sv
// Signal bundle between the E/D pipeline stages and the multiply/divide controller.
// The pipeline side is the master; md_ctrl is the slave.
interface md_ctrl_if;
    logic        start_E;
    logic [1:0]  md_op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        mthi_E;
    logic        mtlo_E;
    logic        hilo_sel_E;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_hi_lo_E;

    modport master (
        output start_E, md_op_E, rs_E, rt_E, mthi_E, mtlo_E, hilo_sel_E, md_use_D,
        input  busy, md_stall, hi, lo, md_hi_lo_E
    );

    modport slave (
        input  start_E, md_op_E, rs_E, rt_E, mthi_E, mtlo_E, hilo_sel_E, md_use_D,
        output busy, md_stall, hi, lo, md_hi_lo_E
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers, with pipeline stall generation.
// The result is computed from latched operands and committed on the last busy cycle.
//
// state | meaning
// IDLE  | no operation in flight; accepts start, mthi and mtlo
// MULT  | mult/multu counting down MULT_CYCLES busy cycles
// DIV   | div/divu counting down DIV_CYCLES busy cycles
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   md
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [63:0]   ext_a, ext_b, prod;
    logic [31:0]   mag_a, mag_b, div_b, q_u, r_u, quo, rem;

    // Sign-extending both operands lets one 64-bit multiplier serve mult and multu.
    assign ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
    assign mag_a = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign mag_b = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_u   = mag_a / div_b;
    assign r_u   = mag_a % div_b;
    assign quo   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - q_u) : q_u;
    assign rem   = (sgn_q && a_q[31]) ? (32'd0 - r_u) : r_u;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start_E) begin
                    a_d   = md.rs_E;
                    b_d   = md.rt_E;
                    sgn_d = ~md.md_op_E[0];
                    if (md.md_op_E[1]) begin
                        state_d = DIV;
                        cnt_d   = CW'(DIV_CYCLES - 1);
                    end else begin
                        state_d = MULT;
                        cnt_d   = CW'(MULT_CYCLES - 1);
                    end
                end else begin
                    if (md.mthi_E) hi_d = md.rs_E;
                    if (md.mtlo_E) lo_d = md.rs_E;
                end
            end
            MULT: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    // A zero divisor burns the full latency but leaves HI/LO alone.
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md.busy       = (state_q != IDLE);
    assign md.md_stall   = ~reset & md.md_use_D & (md.start_E | md.busy);
    assign md.hi         = hi_q;
    assign md.lo         = lo_q;
    assign md.md_hi_lo_E = md.hilo_sel_E ? hi_q : lo_q;
endmodule
